// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory arbiter.
// Imported by the arbiter top and its priority sub-block.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_STARVE_MAX = 2;
    localparam int DEF_TIMEOUT    = 255;

    // Timeout counter width; TIMEOUT is limited to 1..255.
    localparam int TMO_W = 8;

    // Width needed to hold 0..m, at least one bit.
    function automatic int streak_width(input int m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/arb_prio.sv
// Grant selection between I and D requesters.
// D wins by default; I wins once D has won STARVE_MAX times in a row over it.
module arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_d
);

    localparam int SW = streak_width(STARVE_MAX);
    localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          starved;

    // Winner select and streak update for the grant made this cycle.
    always_comb begin
        starved  = i_req && (streak_q == S_MAX);
        grant_d  = d_req && !starved;
        streak_d = streak_q;
        if (grant_en) begin
            if (grant_d && i_req) begin
                if (streak_q != S_MAX) begin
                    streak_d = streak_q + 1'b1;
                end
            end else begin
                streak_d = '0;
            end
        end
    end

    // Streak register; counts D wins while I is kept waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shared memory port arbiter for I-cache and D-cache engines.
// One transaction at a time: select, issue, wait for ack, respond.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t             state_q,  state_d;
    owner_t             owner_q,  owner_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic               wr_q,     wr_d;
    logic [DATA_W-1:0]  wdata_q,  wdata_d;
    logic [TMO_W-1:0]   cnt_q,    cnt_d;
    logic [DATA_W-1:0]  rdata_q,  rdata_d;
    logic               err_q,    err_d;
    logic               i_done_q, i_done_d;
    logic               d_done_q, d_done_d;

    logic grant_en;
    logic grant_d;

    assign grant_en = (state_q == ST_IDLE) && (i_req || d_req);

    arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .d_req   (d_req),
        .grant_en(grant_en),
        .grant_d (grant_d)
    );

    // Next-state, command latch, timeout count and response capture.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    owner_d = grant_d ? OWN_D : OWN_I;
                    addr_d  = grant_d ? d_addr : i_addr;
                    wr_d    = grant_d && d_wr;
                    wdata_d = grant_d ? d_wdata : '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (mem_ack) begin
                    rdata_d  = mem_rdata;
                    err_d    = 1'b0;
                    i_done_d = (owner_q == OWN_I);
                    d_done_d = (owner_q == OWN_D);
                    state_d  = ST_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    i_done_d = (owner_q == OWN_I);
                    d_done_d = (owner_q == OWN_D);
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All arbiter state; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_I;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign i_rdata   = rdata_q;
    assign d_rdata   = rdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_done;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        err;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .STARVE_MAX(2),
        .TIMEOUT   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_done   (i_done),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .err      (err),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for a command, accepts it, acks next cycle, samples the response.
    task automatic run_one(
        input  logic [15:0] rd,
        output logic [15:0] a,
        output int          waits,
        output logic        idn,
        output logic        ddn,
        output logic        e,
        output logic [15:0] rdat,
        output bit          tmo
    );
        waits = 0;
        tmo   = 1'b0;
        a     = '0;
        idn   = 1'b0;
        ddn   = 1'b0;
        e     = 1'b0;
        rdat  = '0;
        do begin
            @(negedge clk);
            waits++;
        end while (!mem_en && waits < 50);
        if (!mem_en) begin
            tmo = 1'b1;
            return;
        end
        a = mem_addr;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        idn       = i_done;
        ddn       = d_done;
        e         = err;
        rdat      = ddn ? d_rdata : i_rdata;
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_wr      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_en, i_done, d_done, err, busy, mem_wr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=000000",
                     {mem_en, i_done, d_done, err, busy, mem_wr});
        end
        checks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0",
                     {mem_addr, mem_wdata, i_rdata, d_rdata});
        end
        rst       = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic test_single_read();
        i_req  = 1'b1;
        i_addr = 16'h0040;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_wr, busy} !== 3'b101 || mem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL rd_issue en/wr/busy=%b addr=%h exp=101 0040",
                     {mem_en, mem_wr, busy}, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || i_done !== 1'b0) begin
            errors++;
            $display("FAIL rd_wait en=%b done=%b exp=0 0", mem_en, i_done);
        end
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        checks++;
        if ({i_done, d_done, err} !== 3'b100 || i_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_resp i/d/err=%b rdata=%h exp=100 beef",
                     {i_done, d_done, err}, i_rdata);
        end
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_done, d_done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL rd_after i/d/busy=%b exp=000", {i_done, d_done, busy});
        end
    endtask

    task automatic test_priority_back_to_back();
        logic [15:0] exp_a [6];
        logic [15:0] a;
        logic [15:0] rdat;
        logic        idn;
        logic        ddn;
        logic        e;
        int          waits;
        bit          tmo;
        exp_a   = '{16'h0100, 16'h0100, 16'h0200,
                    16'h0100, 16'h0100, 16'h0200};
        i_req   = 1'b1;
        i_addr  = 16'h0200;
        d_req   = 1'b1;
        d_wr    = 1'b0;
        d_addr  = 16'h0100;
        for (int k = 0; k < 6; k++) begin
            run_one(16'hA000 + 16'(k), a, waits, idn, ddn, e, rdat, tmo);
            checks++;
            if (tmo) begin
                errors++;
                $display("FAIL prio_timeout grant=%0d got=no_mem_en exp=mem_en", k);
                break;
            end
            checks++;
            if (a !== exp_a[k]) begin
                errors++;
                $display("FAIL prio_order grant=%0d got=%h exp=%h", k, a, exp_a[k]);
            end
            checks++;
            if ({idn, ddn, e} !== {exp_a[k] == 16'h0200, exp_a[k] == 16'h0100, 1'b0}) begin
                errors++;
                $display("FAIL prio_done grant=%0d i/d/err=%b", k, {idn, ddn, e});
            end
            checks++;
            if (rdat !== 16'hA000 + 16'(k)) begin
                errors++;
                $display("FAIL prio_rdata grant=%0d got=%h exp=%h",
                         k, rdat, 16'hA000 + 16'(k));
            end
            checks++;
            if (waits !== ((k == 0) ? 1 : 2)) begin
                errors++;
                $display("FAIL b2b_gap grant=%0d got=%0d exp=%0d",
                         k, waits, (k == 0) ? 1 : 2);
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stalled_write();
        int en_ok = 0;
        mem_ready = 1'b0;
        d_req     = 1'b1;
        d_wr      = 1'b1;
        d_addr    = 16'h0008;
        d_wdata   = 16'h1234;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_en && mem_wr && mem_addr == 16'h0008 && mem_wdata == 16'h1234)
                en_ok++;
            if (k == 6) mem_ready = 1'b1;
        end
        checks++;
        if (en_ok !== 6) begin
            errors++;
            $display("FAIL wr_stall_cmd got=%0d exp=6", en_ok);
        end
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_accept_once en=%b exp=0", mem_en);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'h5555;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        checks++;
        if ({i_done, d_done, err} !== 3'b010) begin
            errors++;
            $display("FAIL wr_done i/d/err=%b exp=010", {i_done, d_done, err});
        end
        d_req = 1'b0;
        d_wr  = 1'b0;
        @(negedge clk);
        checks++;
        if (d_done !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse d_done=%b exp=0", d_done);
        end
    endtask

    task automatic test_timeout();
        int          early = 0;
        logic [15:0] a;
        logic [15:0] rdat;
        logic        idn;
        logic        ddn;
        logic        e;
        int          waits;
        bit          tmo;
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h0300;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("FAIL tmo_issue en=%b exp=1", mem_en);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (d_done || err || !busy) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL tmo_early got=%0d exp=0", early);
        end
        @(negedge clk);
        checks++;
        if ({i_done, d_done, err} !== 3'b011 || d_rdata !== 16'h0) begin
            errors++;
            $display("FAIL tmo_resp i/d/err=%b rdata=%h exp=011 0000",
                     {i_done, d_done, err}, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 16'h9999;
        @(negedge clk);
        checks++;
        if ({i_done, d_done, err, busy, mem_en} !== 5'b0) begin
            errors++;
            $display("FAIL tmo_late_ack i/d/err/busy/en=%b exp=00000",
                     {i_done, d_done, err, busy, mem_en});
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        i_req     = 1'b1;
        i_addr    = 16'h0044;
        run_one(16'h1111, a, waits, idn, ddn, e, rdat, tmo);
        checks++;
        if (tmo || a !== 16'h0044 || {idn, ddn, e} !== 3'b100 || rdat !== 16'h1111) begin
            errors++;
            $display("FAIL tmo_next tmo=%b addr=%h i/d/err=%b rdata=%h exp=0 0044 100 1111",
                     tmo, a, {idn, ddn, e}, rdat);
        end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int          w = 0;
        logic [15:0] a;
        logic [15:0] rdat;
        logic        idn;
        logic        ddn;
        logic        e;
        int          waits;
        bit          tmo;
        i_req  = 1'b1;
        i_addr = 16'h0200;
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h0100;
        run_one(16'h2222, a, waits, idn, ddn, e, rdat, tmo);
        checks++;
        if (tmo || a !== 16'h0100 || ddn !== 1'b1) begin
            errors++;
            $display("FAIL rstw_first tmo=%b addr=%h d_done=%b exp=0 0100 1", tmo, a, ddn);
        end
        do begin
            @(negedge clk);
            w++;
        end while (!mem_en && w < 50);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL rstw_second en=%b addr=%h exp=1 0100", mem_en, mem_addr);
        end
        @(negedge clk);
        rst   = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, i_done, d_done, err, busy, mem_wr} !== 6'b0 ||
            {mem_addr, mem_wdata, d_rdata} !== 48'h0) begin
            errors++;
            $display("FAIL rstw_outputs ctl=%b addr=%h rdata=%h exp=0",
                     {mem_en, i_done, d_done, err, busy, mem_wr}, mem_addr, d_rdata);
        end
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        @(negedge clk);
        checks++;
        if ({i_done, d_done, err, busy} !== 4'b0) begin
            errors++;
            $display("FAIL rstw_stray_ack i/d/err/busy=%b exp=0000",
                     {i_done, d_done, err, busy});
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        i_req     = 1'b1;
        run_one(16'h3333, a, waits, idn, ddn, e, rdat, tmo);
        checks++;
        if (tmo || a !== 16'h0200 || {idn, ddn, e} !== 3'b100 || rdat !== 16'h3333) begin
            errors++;
            $display("FAIL rstw_i_first tmo=%b addr=%h i/d/err=%b rdata=%h exp=0 0200 100 3333",
                     tmo, a, {idn, ddn, e}, rdat);
        end
        i_req = 1'b0;
        @(negedge clk);
        i_req = 1'b1;
        d_req = 1'b1;
        run_one(16'h4444, a, waits, idn, ddn, e, rdat, tmo);
        checks++;
        if (tmo || a !== 16'h0100 || ddn !== 1'b1) begin
            errors++;
            $display("FAIL rstw_streak_clr tmo=%b addr=%h d_done=%b exp=0 0100 1", tmo, a, ddn);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority_back_to_back();
        test_stalled_write();
        test_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=time_limit exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the shared main-memory port between the instruction-cache and data-cache miss/write-back engines. It sequences one memory transaction at a time: select, issue, wait for acknowledge, return data. It sits between the two cache controllers and the unified memory in `proc_hier`. It provides D-side priority with a bounded starvation guard for the I-side, plus a per-transaction timeout.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `STARVE_MAX`, 2, consecutive D grants allowed while I is waiting before I must win
- `TIMEOUT`, 255, cycles to wait for `mem_ack` before aborting; range 1..255

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  1  I-side request; held until `i_done`
- `i_addr`  in  ADDR_W  I-side address; always a read
- `i_done`  out  1  one-cycle completion pulse to the I-side
- `i_rdata`  out  DATA_W  read data, valid with `i_done`
- `d_req`  in  1  D-side request; held until `d_done`
- `d_wr`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  D-side address
- `d_wdata`  in  DATA_W  D-side write data
- `d_done`  out  1  one-cycle completion pulse to the D-side
- `d_rdata`  out  DATA_W  read data, valid with `d_done`
- `err`  out  1  pulses with `*_done` when the transaction timed out
- `mem_en`  out  1  one-cycle command strobe to memory
- `mem_wr`  out  1  write command, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  command address
- `mem_wdata`  out  DATA_W  command write data
- `mem_ready`  in  1  memory can accept a command this cycle
- `mem_ack`  in  1  transaction complete; read data valid
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  arbiter is not in IDLE

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any request is pending, choose a winner, latch `owner`, address, write flag and write data, then go to ISSUE.
- **Priority:**
  - D wins when both requesters are pending, unless `streak == STARVE_MAX`; in that case I wins.
  - `streak` increments on each D grant made while `i_req` = 1.
  - `streak` clears on any I grant, and on a D grant made while `i_req` = 0.
  - `streak` saturates at `STARVE_MAX`.
- **ISSUE:**
  - `mem_en` = 1 combinationally, with the latched command, while `mem_ready` = 0.
  - The command is accepted in the first cycle with `mem_ready` = 1; go to WAIT and clear the timeout counter.
- **WAIT:**
  - `mem_en` = 0.
  - On `mem_ack`, register `mem_rdata` into the read-data register, set `err_q` = 0 and go to RESP.
  - If the counter reaches `TIMEOUT` without `mem_ack`, set read data to 0, set `err_q` = 1 and go to RESP.
  - `mem_ack` in the same cycle as the timeout wins: treat it as a normal completion.
- **RESP:**
  - Pulse the owner's `*_done` and drive `err` = `err_q` for exactly one cycle.
  - Return to IDLE.
- **Ignored inputs:**
  - `mem_ack` outside WAIT is ignored.
  - Requests dropped before `done` are a protocol violation; the arbiter completes the latched transaction regardless.
- **Reset:**
  - `rst` in any state forces IDLE and clears `streak`, the timeout counter and `owner`.
  - All outputs go to 0: `mem_en`, `i_done`, `d_done`, `err`, `busy`, and the data/address outputs.
  - An in-flight memory transaction is abandoned; any later `mem_ack` is ignored in IDLE.

## Timing
- **Minimum latency:** request in IDLE at cycle 0 → ISSUE at 1 → (`mem_ready` = 1) WAIT at 2 → `mem_ack` at 2 → RESP at 3, `done` high in cycle 3. That is 3 cycles plus memory latency.
- **Back-to-back:** the earliest next grant is in IDLE at cycle 4.
- **Rule:** one transaction outstanding at most; never two `done` pulses in one cycle.
- **Timeout:** `done` + `err` arrive `TIMEOUT` + 1 cycles after ISSUE→WAIT.
- **Read data:** `i_rdata`/`d_rdata` hold their value from RESP until the next RESP.

## Structure
- **Package `mem_arb_pkg`:**
  - FSM state enum.
  - Owner encoding: `OWN_I` = 0, `OWN_D` = 1.
  - Default parameter constants.
- **Sub-module `arb_prio`:**
  - Combinational grant logic plus the `streak` register.
  - Ports: `clk`, `rst`, `i_req`, `d_req`, `grant_en`, `grant_d`.
  - Keeps the fairness policy unit-testable.
- **Top:** FSM, command latch, timeout counter and response register.

## Test plan
- **Single I read:** `i_req`, `addr` 0x0040, `mem_ready` = 1, `mem_ack` 2 cycles after issue with 0xBEEF → `i_done` one cycle with `i_rdata` = 0xBEEF, `err` = 0, `d_done` never asserted.
- **Simultaneous requests held continuously:**
  - Stimulus: D read 0x0100 and I read 0x0200.
  - Required grant order: D, D, I, D, D, I.
  - `streak` returns to 0 after each I grant.
- **D write with stalled memory:**
  - Stimulus: 0x1234 → 0x0008, `mem_ready` = 0 for 5 cycles.
  - `mem_en` stays high with a stable command for 6 cycles.
  - Exactly one accepted cycle, then `d_done` after ack.
- **Timeout:**
  - Stimulus: `TIMEOUT` = 4, no `mem_ack`.
  - `d_done` and `err` pulse together 5 cycles after acceptance, `d_rdata` = 0.
  - A late `mem_ack` is ignored and the next request proceeds normally.
- **Reset during WAIT:**
  - `rst` for 1 cycle → all outputs 0, `busy` = 0.
  - A stray `mem_ack` next cycle produces no `done`.
  - The subsequent I request is granted first regardless of the prior streak.
